pc_ctrl_irq_stack: RTL and testbench
====================================

Name: pc_ctrl_irq_stack

Overview:
- Parametrised next-generation program-counter controller for the 2-stage-issue ez8 pipeline: PC fetch stage → decode → read/exec → write.
- Integrates a configurable-depth return stack, so no external stack instance is needed.
- Adds N prioritised interrupt channels, each with its own vector, plus a global interrupt-enable that is cleared on entry and restored by reti.
- Generates kill for mis-issued instructions and save_accum on interrupt entry.

Parameters:
- PC_W, 12, program counter / address width.
- STACK_DEPTH, 8, return-stack entries (≥2).
- N_IRQ, 4, interrupt request channels (1..16).
- VEC_BASE, 4, vector of channel 0.
- VEC_STRIDE, 2, vector spacing; channel i vectors to VEC_BASE + i*VEC_STRIDE (mod 2^PC_W).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- pause  input  1  freeze all state this cycle.
- skip  input  1  read/exec-stage skip taken.
- goto  input  1  decode-stage goto/call.
- call  input  1  with goto: push return address.
- ret  input  1  decode-stage return.
- reti  input  1  decode-stage return-from-interrupt.
- goto_addr  input  PC_W  jump target.
- irq_req  input  N_IRQ  level interrupt requests.
- pc_out  output  PC_W  current PC.
- kill  output  1  cancel write-stage instruction.
- save_accum  output  1  pulse: save accumulator context.
- irq_ack  output  N_IRQ  one-hot pulse for the channel taken.
- irq_en  output  1  global interrupt enable.
- stack_level  output  $clog2(STACK_DEPTH+1)  entries in use.
- stopped  output  1  processor halted.
- error  output  1  fatal fault, sticky until reset.

Behaviour:
- Reset (async, reset==0):
  - pc=0, kill_shift=2'b11, state=RUN, sp=0, irq_en=1.
  - stopped=0, error=0, save_accum=0, irq_ack=0, stop_wait=0.
  - Reset mid-operation discards pending interrupt and stack contents.
- kill = kill_shift[1]. Each rule below shifts kill_shift as {kill_shift[0], x}.
- save_accum and irq_ack are single-cycle pulses; they clear on the next clock edge regardless of pause.
- pause=1 or stopped=1: pc, kill_shift, stack, state and flags hold; no push/pop.
- Pending interrupt = irq_en & |irq_req.
  - Lowest index wins.
  - The winning index is latched at detection (irq_sel).
  - Requests deasserted after detection are still serviced.
- Evaluation priority per active cycle (first match):
  1. SAVE:
     - If stack full: error=1, stopped=1, no push.
     - Else push pc.
     - Always: pc=vector(irq_sel), kill x=1, save_accum=1, irq_ack[irq_sel]=1, irq_en=0, state→RUN.
  2. WAIT:
     - If skip & !kill_shift[1]: pc=pc+1.
     - kill x=1, state→SAVE.
  3. skip & !kill_shift[1]:
     - Pending interrupt: kill_shift=2'b11, latch irq, state→SAVE, pc unchanged.
     - Else: kill_shift=2'b10, pc=pc+1.
  4. goto & !kill_shift[0]:
     - If call: push pc; if full, error=1 and stopped=1.
     - pc=goto_addr, kill x=1.
     - Pending interrupt: latch irq, state→SAVE.
  5. (ret|reti) & !kill_shift[0]:
     - Stack empty:
       - ret: stop_wait=1.
       - reti: error=1, stopped=1.
     - Stack not empty:
       - pop, pc=top.
       - reti additionally sets irq_en=1.
       - Pending interrupt: latch irq, state→SAVE. For reti, the pending check uses the new irq_en.
     - kill x=1 in all cases.
  6. stop_wait: stopped=1, stop_wait=0.
  7. Default:
     - Pending interrupt: kill x=1, latch irq, state→WAIT.
     - Else: kill x=0, pc=pc+1.
- PC arithmetic wraps modulo 2^PC_W (all-ones+1 → 0).
- Stack is LIFO. Push and pop never occur in the same cycle. Pushed value is pc at that cycle, i.e. the return address.
- stack_level reflects sp after each update; full when sp==STACK_DEPTH.

Optional Feature:
- PC_CTRL_STACK_WRAP_EN defined:
  - Stack is circular.
  - Push when full overwrites the oldest entry; stack_level stays at STACK_DEPTH.
  - error is never raised for overflow (call or interrupt entry); execution continues.
- Undefined: overflow sets error=1 and stopped=1 as above.

Test Plan:
- Reset: hold reset=0 with clock running, release → pc_out=0, kill=1 for 2 cycles, then 0; pc_out increments 1,2,3; irq_en=1; stack_level=0.
- Call/ret: goto=1, call=1, goto_addr=0x100 at pc=5 → stack_level=1, pc=0x100, kill=1 for one write cycle. Later ret → pc=5, stack_level=0.
- Priority interrupt:
  - irq_req=4'b0110 in a plain cycle → WAIT, then SAVE.
  - Expect irq_ack=4'b0010, pc_out=VEC_BASE+VEC_STRIDE=6, save_accum=1 for one cycle, irq_en=0.
  - Pushed return address equals first unexecuted pc.
  - reti → irq_en=1, pc restored.
- Skip during interrupt: skip=1 with kill_shift[1]=0 and irq_req[0]=1 → kill_shift=11, direct SAVE next cycle, vector=4, return address not incremented.
- Overflow: STACK_DEPTH+1 nested calls → error=1, stopped=1, pc frozen. With PC_CTRL_STACK_WRAP_EN: no error, stack_level=STACK_DEPTH.
- Exit / faults:
  - ret with empty stack → stopped=1 two cycles later, error=0.
  - reti on empty stack → error=1.
  - pause=1 for 3 cycles → pc_out and kill unchanged.

Source files
------------

// File: rtl/pc_ctrl_irq_stack.sv
// pc_ctrl_irq_stack: program-counter controller for the ez8 pipeline with an
// integrated return stack, prioritised vectored interrupts and kill generation.
// Optional feature: define PC_CTRL_STACK_WRAP_EN for a circular return stack
// that overwrites its oldest entry on overflow instead of faulting.
module pc_ctrl_irq_stack #(
    parameter int unsigned PC_W        = 12,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned N_IRQ       = 4,
    parameter int unsigned VEC_BASE    = 4,
    parameter int unsigned VEC_STRIDE  = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             pause_i,
    input  logic                             skip_i,
    input  logic                             goto_i,
    input  logic                             call_i,
    input  logic                             ret_i,
    input  logic                             reti_i,
    input  logic [PC_W-1:0]                  goto_addr_i,
    input  logic [N_IRQ-1:0]                 irq_req_i,
    output logic [PC_W-1:0]                  pc_out_o,
    output logic                             kill_o,
    output logic                             save_accum_o,
    output logic [N_IRQ-1:0]                 irq_ack_o,
    output logic                             irq_en_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level_o,
    output logic                             stopped_o,
    output logic                             error_o
);

    localparam int unsigned LvlW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(STACK_DEPTH);
    localparam int unsigned IdxW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

`ifdef PC_CTRL_STACK_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StRun, StWait, StSave} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [1:0]        kill_q, kill_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic              irq_en_q, irq_en_d;
    logic [IdxW-1:0]   irq_sel_q, irq_sel_d;
    logic              stop_wait_q, stop_wait_d;
    logic              stopped_q, stopped_d;
    logic              error_q, error_d;
    logic              save_accum_q, save_accum_d;
    logic [N_IRQ-1:0]  irq_ack_q, irq_ack_d;

    logic [PC_W-1:0]   stack_q [STACK_DEPTH];

    logic              push, pop;
    logic              full, empty, overflow;
    logic [PtrW-1:0]   ptr_inc, ptr_dec;
    logic [IdxW-1:0]   lowest;
    logic [PC_W-1:0]   vec_pc;
    logic              pending;

    assign full     = (level_q == LvlW'(STACK_DEPTH));
    assign empty    = (level_q == '0);
    // Overflow only faults when the stack is not circular.
    assign overflow = full & ~WrapEn;
    assign ptr_inc  = (ptr_q == PtrW'(STACK_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_dec  = (ptr_q == '0) ? PtrW'(STACK_DEPTH - 1) : ptr_q - 1'b1;
    assign pending  = irq_en_q & (|irq_req_i);
    assign vec_pc   = PC_W'(VEC_BASE) + PC_W'(irq_sel_q) * PC_W'(VEC_STRIDE);

    // Lowest-index active request wins.
    always_comb begin
        lowest = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_req_i[i]) lowest = IdxW'(i);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StRun;
        else         state_q <= state_d;
    end

    // Next-state and datapath decision, first matching rule wins.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        level_d      = level_q;
        ptr_d        = ptr_q;
        irq_en_d     = irq_en_q;
        irq_sel_d    = irq_sel_q;
        stop_wait_d  = stop_wait_q;
        stopped_d    = stopped_q;
        error_d      = error_q;
        save_accum_d = 1'b0;
        irq_ack_d    = '0;
        push         = 1'b0;
        pop          = 1'b0;

        if (!pause_i && !stopped_q) begin
            if (state_q == StSave) begin
                if (overflow) begin
                    error_d   = 1'b1;
                    stopped_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
                pc_d         = vec_pc;
                kill_d       = {kill_q[0], 1'b1};
                save_accum_d = 1'b1;
                irq_ack_d    = N_IRQ'(1) << irq_sel_q;
                irq_en_d     = 1'b0;
                state_d      = StRun;
            end else if (state_q == StWait) begin
                if (skip_i && !kill_q[1]) pc_d = pc_q + 1'b1;
                kill_d  = {kill_q[0], 1'b1};
                state_d = StSave;
            end else if (skip_i && !kill_q[1]) begin
                if (pending) begin
                    kill_d    = 2'b11;
                    irq_sel_d = lowest;
                    state_d   = StSave;
                end else begin
                    kill_d = 2'b10;
                    pc_d   = pc_q + 1'b1;
                end
            end else if (goto_i && !kill_q[0]) begin
                if (call_i) begin
                    if (overflow) begin
                        error_d   = 1'b1;
                        stopped_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                pc_d   = goto_addr_i;
                kill_d = {kill_q[0], 1'b1};
                if (pending) begin
                    irq_sel_d = lowest;
                    state_d   = StSave;
                end
            end else if ((ret_i || reti_i) && !kill_q[0]) begin
                if (empty) begin
                    if (ret_i) begin
                        stop_wait_d = 1'b1;
                    end else begin
                        error_d   = 1'b1;
                        stopped_d = 1'b1;
                    end
                end else begin
                    pop  = 1'b1;
                    pc_d = stack_q[ptr_dec];
                    if (ret_i) begin
                        if (pending) begin
                            irq_sel_d = lowest;
                            state_d   = StSave;
                        end
                    end else begin
                        // reti re-enables interrupts, so any request is pending.
                        irq_en_d = 1'b1;
                        if (|irq_req_i) begin
                            irq_sel_d = lowest;
                            state_d   = StSave;
                        end
                    end
                end
                kill_d = {kill_q[0], 1'b1};
            end else if (stop_wait_q) begin
                stopped_d   = 1'b1;
                stop_wait_d = 1'b0;
                kill_d      = {kill_q[0], 1'b1};
            end else begin
                if (pending) begin
                    kill_d    = {kill_q[0], 1'b1};
                    irq_sel_d = lowest;
                    state_d   = StWait;
                end else begin
                    kill_d = {kill_q[0], 1'b0};
                    pc_d   = pc_q + 1'b1;
                end
            end

            if (push) begin
                ptr_d = ptr_inc;
                // A circular stack saturates its level once full.
                if (!full) level_d = level_q + 1'b1;
            end else if (pop) begin
                ptr_d   = ptr_dec;
                level_d = level_q - 1'b1;
            end
        end
    end

    // Datapath and flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q         <= '0;
            kill_q       <= 2'b11;
            level_q      <= '0;
            ptr_q        <= '0;
            irq_en_q     <= 1'b1;
            irq_sel_q    <= '0;
            stop_wait_q  <= 1'b0;
            stopped_q    <= 1'b0;
            error_q      <= 1'b0;
            save_accum_q <= 1'b0;
            irq_ack_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            level_q      <= level_d;
            ptr_q        <= ptr_d;
            irq_en_q     <= irq_en_d;
            irq_sel_q    <= irq_sel_d;
            stop_wait_q  <= stop_wait_d;
            stopped_q    <= stopped_d;
            error_q      <= error_d;
            save_accum_q <= save_accum_d;
            irq_ack_q    <= irq_ack_d;
        end
    end

    // Return-stack storage; validity is tracked by level_q, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) stack_q[ptr_q] <= pc_q;
    end

    // Outputs.
    always_comb begin
        pc_out_o      = pc_q;
        kill_o        = kill_q[1];
        save_accum_o  = save_accum_q;
        irq_ack_o     = irq_ack_q;
        irq_en_o      = irq_en_q;
        stack_level_o = level_q;
        stopped_o     = stopped_q;
        error_o       = error_q;
    end

endmodule

// File: tb/tb_pc_ctrl_irq_stack.sv
// Directed bench for pc_ctrl_irq_stack: expectations are queued before each
// clock edge and checked against the DUT shortly after it.
module tb_pc_ctrl_irq_stack;

    localparam int unsigned PC_W        = 12;
    localparam int unsigned STACK_DEPTH = 8;
    localparam int unsigned N_IRQ       = 4;
    localparam int unsigned LVL_W       = $clog2(STACK_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pause, skip, goto_r, call, ret, reti;
    logic [PC_W-1:0]  goto_addr;
    logic [N_IRQ-1:0] irq_req;
    logic [PC_W-1:0]  pc_out;
    logic             kill, save_accum, irq_en, stopped, error;
    logic [N_IRQ-1:0] irq_ack;
    logic [LVL_W-1:0] stack_level;

    pc_ctrl_irq_stack #(
        .PC_W       (PC_W),
        .STACK_DEPTH(STACK_DEPTH),
        .N_IRQ      (N_IRQ),
        .VEC_BASE   (4),
        .VEC_STRIDE (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pause_i      (pause),
        .skip_i       (skip),
        .goto_i       (goto_r),
        .call_i       (call),
        .ret_i        (ret),
        .reti_i       (reti),
        .goto_addr_i  (goto_addr),
        .irq_req_i    (irq_req),
        .pc_out_o     (pc_out),
        .kill_o       (kill),
        .save_accum_o (save_accum),
        .irq_ack_o    (irq_ack),
        .irq_en_o     (irq_en),
        .stack_level_o(stack_level),
        .stopped_o    (stopped),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic want(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input string tag);
        case (tag)
            "pc":      return 32'(pc_out);
            "kill":    return 32'(kill);
            "level":   return 32'(stack_level);
            "irq_en":  return 32'(irq_en);
            "ack":     return 32'(irq_ack);
            "sacc":    return 32'(save_accum);
            "stopped": return 32'(stopped);
            "error":   return 32'(error);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.tag);
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle();
        pause = 0; skip = 0; goto_r = 0; call = 0; ret = 0; reti = 0;
        goto_addr = '0; irq_req = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state.
        want("pc", 0); want("kill", 1); want("irq_en", 1); want("level", 0);
        want("stopped", 0); want("error", 0); want("sacc", 0); want("ack", 0);
        drain();
        want("pc", 1); want("kill", 1); step();
        want("pc", 2); want("kill", 0); step();
        want("pc", 3); want("kill", 0); step();
        step(); step();                              // pc=5

        // Call and return.
        goto_r = 1; call = 1; goto_addr = 12'h100;
        want("pc", 12'h100); want("level", 1); want("kill", 0); step();
        idle();
        want("pc", 12'h101); want("kill", 1); step();
        want("pc", 12'h102); want("kill", 0); step();
        ret = 1;
        want("pc", 5); want("level", 0); step();
        idle();
        step(); step();                              // pc=7, kill_shift=00

        // Prioritised interrupt through WAIT then SAVE; request withdrawn early.
        irq_req = 4'b0110;
        want("pc", 7); want("kill", 0); step();      // -> WAIT
        idle();
        want("pc", 7); want("sacc", 0); step();      // -> SAVE
        want("pc", 6); want("ack", 4'b0010); want("sacc", 1); want("irq_en", 0);
        want("level", 1); want("kill", 1); step();
        want("sacc", 0); want("ack", 0); want("pc", 7); step();
        step();                                      // pc=8
        reti = 1;
        want("pc", 7); want("irq_en", 1); want("level", 0); step();
        idle();
        step(); step();                              // pc=9

        // Skip while an interrupt is pending goes straight to SAVE.
        skip = 1; irq_req = 4'b0001;
        want("pc", 9); want("kill", 1); step();
        idle();
        want("pc", 4); want("ack", 4'b0001); want("level", 1); want("irq_en", 0); step();
        step(); step();                              // pc=6
        reti = 1;
        want("pc", 9); want("level", 0); want("irq_en", 1); step();
        idle();
        step(); step();                              // pc=11

        // Plain skip, then pause holds pc and kill.
        skip = 1;
        want("pc", 12); want("kill", 1); step();
        idle();
        pause = 1;
        for (int i = 0; i < 3; i++) begin
            want("pc", 12); want("kill", 1); step();
        end
        pause = 0;
        want("pc", 13); want("kill", 0); step();

        // PC wraps modulo 2^PC_W.
        goto_r = 1; goto_addr = 12'hFFE;
        want("pc", 12'hFFE); step();
        idle();
        want("pc", 12'hFFF); step();
        want("pc", 0); step();

        // Nested calls up to and past the stack depth.
        do_reset();
        step();                                      // kill_shift=10
        for (int i = 0; i < STACK_DEPTH; i++) begin
            goto_r = 1; call = 1; goto_addr = 12'h200 + 12'(i);
            want("level", i + 1); want("pc", 12'h200 + 12'(i)); step();
            idle();
            step();
        end
        goto_r = 1; call = 1; goto_addr = 12'h2AA;
`ifdef PC_CTRL_STACK_WRAP_EN
        want("error", 0); want("stopped", 0); want("level", STACK_DEPTH); want("pc", 12'h2AA);
        step();
        idle();
        want("pc", 12'h2AB); want("level", STACK_DEPTH); step();
`else
        want("error", 1); want("stopped", 1); want("level", STACK_DEPTH); want("pc", 12'h2AA);
        step();
        idle();
        want("pc", 12'h2AA); want("stopped", 1); step();
        want("pc", 12'h2AA); want("error", 1); step();
`endif

        // ret on an empty stack halts two cycles later without error.
        do_reset();
        want("level", 0); want("error", 0); drain();
        step();
        ret = 1;
        want("stopped", 0); want("pc", 1); step();
        idle();
        want("stopped", 1); want("error", 0); step();
        want("pc", 1); want("stopped", 1); step();

        // reti on an empty stack is fatal.
        do_reset();
        step();
        reti = 1;
        want("error", 1); want("stopped", 1); step();
        idle();
        want("error", 1); want("pc", 1); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
